// File: rtl/mioc_gate_test_seq.sv
// MIOC single-gate characterisation pattern sequencer.
// Optional stop-on-first-fail: define MIOC_SEQ_STOP_ON_FAIL_EN.
module mioc_gate_test_seq #(
  parameter int PAT_W      = 4,
  parameter int NUM_PAT    = 16,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2**PAT_W-1:0]   exp_tt,
  output logic [PAT_W-1:0]      pat_out,
  input  logic                  dut_z,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  first_fail_vld,
  output logic [PAT_W-1:0]      first_fail_pat,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [PAT_W+1:0]      log_data
);

  localparam int IDX_W = PAT_W + 1;
  localparam int SC_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_LOG,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               ffv_q, ffv_d;
  logic [PAT_W-1:0]   ffp_q, ffp_d;
  logic [PAT_W+1:0]   log_q, log_d;
  logic               zs1_q, zs_q;
  logic               mis;
  logic               last;

  // Two-flop synchroniser for the asynchronous gate output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zs1_q <= 1'b0;
      zs_q  <= 1'b0;
    end else begin
      zs1_q <= dut_z;
      zs_q  <= zs1_q;
    end
  end

  // Sequencer next-state and datapath updates; abort overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sc_d    = sc_q;
    pat_d   = pat_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffp_d   = ffp_q;
    log_d   = log_q;
    mis     = zs_q ^ exp_tt[idx_q[PAT_W-1:0]];
    last    = (idx_q == IDX_LAST);
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
    last    = last | log_q[0];
`endif
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pat_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_APPLY;
            idx_d   = '0;
            err_d   = '0;
            ffv_d   = 1'b0;
          end
        end
        S_APPLY: begin
          pat_d   = idx_q[PAT_W-1:0];
          sc_d    = '0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) state_d = S_SAMPLE;
        end
        S_SAMPLE: begin
          if (mis) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffp_d = idx_q[PAT_W-1:0];
            end
          end
          log_d   = {idx_q[PAT_W-1:0], zs_q, mis};
          state_d = S_LOG;
        end
        S_LOG: begin
          if (log_ready) begin
            if (last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_APPLY;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sc_q    <= '0;
      pat_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffp_q   <= '0;
      log_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sc_q    <= sc_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffp_q   <= ffp_d;
      log_q   <= log_d;
    end
  end

  assign pat_out        = pat_q;
  assign busy           = (state_q == S_APPLY)  ||
                          (state_q == S_SETTLE) ||
                          (state_q == S_SAMPLE) ||
                          (state_q == S_LOG);
  assign done           = (state_q == S_DONE);
  assign log_valid      = (state_q == S_LOG);
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_pat = ffp_q;
  assign log_data       = log_q;

endmodule

// File: doc/mioc_gate_test_seq.md
Name: mioc_gate_test_seq

Overview:
- Pattern sequencer for MIOC ASIC single-gate characterisation.
- Sweeps input patterns onto a gate under test, waits a programmable settle time, samples the gate output through a synchroniser, and compares it against a 2^PAT_W-entry expected truth table.
- Counts and logs mismatches.
- Sits between the test controller (start/abort, results) and the gate pins (in1..in4, z).

Parameters:
- PAT_W, 4, width of the applied pattern (gate input count).
- NUM_PAT, 16, number of patterns swept, 0..NUM_PAT-1; legal range 1..2^PAT_W.
- SETTLE_CYC, 16, clock cycles held after applying a pattern before sampling; minimum 3.
- CNT_W, 5, width of the mismatch counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- abort  in  1  level; abandons the sweep.
- exp_tt  in  2^PAT_W  expected z per pattern; bit k is the expected z for pattern k. Sampled live.
- pat_out  out  PAT_W  drives the gate inputs; MSB = in1, LSB = in4.
- dut_z  in  1  raw gate output; asynchronous.
- busy  out  1  high from APPLY through LOG.
- done  out  1  high in DONE state.
- err_cnt  out  CNT_W  mismatches in the current or last sweep; saturating.
- first_fail_vld  out  1  at least one mismatch seen this sweep.
- first_fail_pat  out  PAT_W  index of the first mismatching pattern.
- log_valid  out  1  per-pattern result available.
- log_ready  in  1  consumer accepts log_data.
- log_data  out  PAT_W+2  {pattern, sampled z, mismatch}.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all outputs 0; pattern index 0; synchroniser flops 0.
- dut_z passes through a 2-flop synchroniser (z_s). The compare uses z_s only.
- States:
  - IDLE: pat_out = 0. start → APPLY with idx = 0, err_cnt = 0, first_fail_vld = 0.
  - APPLY (1 cycle): pat_out <= idx; settle counter cleared; → SETTLE.
  - SETTLE: counter increments each cycle. After SETTLE_CYC cycles in SETTLE → SAMPLE. pat_out is held stable.
  - SAMPLE (1 cycle):
    - mis = z_s XOR exp_tt[idx].
    - If mis: err_cnt increments, saturating at 2^CNT_W-1.
    - If mis and !first_fail_vld: first_fail_pat <= idx and first_fail_vld <= 1.
    - Capture log_data = {idx, z_s, mis}. → LOG.
  - LOG: log_valid = 1, with log_data stable until the log_valid & log_ready cycle. On that handshake:
    - if idx == NUM_PAT-1 → DONE;
    - else idx+1 → APPLY.
    - log_valid drops the cycle after the handshake.
  - DONE: done = 1. pat_out holds the last pattern; results are held. start → APPLY (new sweep, results cleared). Otherwise remains.
- Per-pattern latency: SETTLE_CYC+3 cycles with log_ready tied high.
- Full sweep: NUM_PAT*(SETTLE_CYC+3) cycles from the start-cycle edge to done rising.
- start while busy: ignored.
- abort (any state except IDLE): → IDLE next cycle; log_valid, busy and done drop; pat_out = 0. err_cnt and first_fail_* retain their values until the next start. abort has priority over start and over the log handshake in the same cycle.
- Backpressure: log_ready low stalls in LOG indefinitely. pat_out stays held, so the gate stays biased.
- NUM_PAT = 1: a single APPLY/SETTLE/SAMPLE/LOG pass, then DONE.
- idx never wraps; the counter width is PAT_W+1 internally to avoid overflow when NUM_PAT = 2^PAT_W.

Optional Feature:
- Macro: MIOC_SEQ_STOP_ON_FAIL_EN.
- Defined: after the LOG handshake of the first mismatching pattern, go to DONE instead of advancing; err_cnt = 1 and first_fail_pat = the failing index.
- Undefined: the sweep always completes all NUM_PAT patterns regardless of mismatches.

Test Plan:
- NAND4 model (z = ~&pat), exp_tt = 16'h7FFF, SETTLE_CYC = 16, log_ready = 1, pulse start → pat_out steps 0..15; 16 logs with mis = 0; done rises 304 cycles after start; err_cnt = 0; first_fail_vld = 0.
- Same run with the model forced to z = 1 at pattern 4'b1111 → one log {4'hF, 1, 1}; err_cnt = 1; first_fail_pat = 15.
- Stuck-at-0 model, exp_tt = 16'h7FFF, CNT_W = 3 → err_cnt saturates at 7; first_fail_pat = 0.
- log_ready held low for 50 cycles at pattern 3 → log_valid and log_data stable; pat_out = 3 throughout; sweep resumes on ready; no lost or duplicated logs.
- abort asserted during SETTLE of pattern 7 → IDLE next cycle; pat_out = 0; busy = 0. A later start restarts at pattern 0 with err_cnt cleared.
- rst_n pulsed low mid-sweep (asynchronous, off clock edge) → all outputs 0 immediately. With MIOC_SEQ_STOP_ON_FAIL_EN and a fail at pattern 2 → done after the third log; err_cnt = 1.
